easyaxi_slv_rd: RTL and testbench
=================================

# easyaxi_slv_rd

AXI4 read-channel responder (slave) for the EasyAXI design. Accepts read requests on the AR channel from the EasyAXI master and returns burst data on the R channel from an internal word-addressed memory. One transaction is in flight at a time. Sits under EASYAXI_TOP opposite the master's read path and is driven by the top-level `enable`.

## Interface
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width (32 or 64)
- ID_W, 4, ARID/RID width
- MEM_DEPTH, 256, memory depth in DATA_W words (power of two)

- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- enable  in  1  when low, no new AR is accepted; an in-flight burst still completes
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arid  in  ID_W  transaction ID
- araddr  in  ADDR_W  byte start address
- arlen  in  8  beats minus 1
- arsize  in  3  log2 of bytes per beat
- arburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
- rvalid  out  1  R valid
- rready  in  1  R ready
- rid  out  ID_W  echoes the accepted arid
- rdata  out  DATA_W  read data
- rresp  out  2  0=OKAY, 2=SLVERR
- rlast  out  1  final beat of the burst
- mem_we  in  1  backdoor preload write enable; bench only
- mem_waddr  in  log2(MEM_DEPTH)  backdoor word address
- mem_wdata  in  DATA_W  backdoor write data

## Operation
- FSM states: IDLE and BURST. Reset puts the FSM in IDLE.
- In IDLE, `arready = enable`. When `arvalid && arready`, the block latches arid, araddr, arlen, arsize and arburst, sets the beat counter to 0, evaluates the error flag, and moves to BURST.
- In BURST:
  - `arready = 0`.
  - `rvalid = 1`.
  - `rdata` is the memory word at `addr >> log2(DATA_W/8)`. It is 0 if the error flag is set or the word index is ≥ MEM_DEPTH.
  - `rlast = (beat == len)`.
- On each `rvalid && rready`, the address advances and the beat counter increments.
- On the last beat's handshake, the FSM returns to IDLE.
- Address advance per beat (size S = 2^arsize bytes):
  - FIXED: the address is unchanged.
  - INCR: `addr += S`, computed modulo 2^ADDR_W.
  - WRAP: with wrap boundary W = (len+1)·S and base = start & ~(W−1), `addr = base + ((addr + S − base) mod W)`.
- The error flag is fixed for the whole burst. A burst is SLVERR if any of these holds:
  - `arsize > log2(DATA_W/8)`;
  - `arburst == 3`;
  - `arburst == WRAP` and `arlen ∉ {1,3,7,15}`;
  - `arburst == WRAP` and araddr is not aligned to S.
- Per-beat SLVERR: a beat whose word index is ≥ MEM_DEPTH returns rresp=2 and rdata=0. The burst is not truncated.
- Memory has no reset; the bench preloads it through the backdoor port. A backdoor write takes effect in the next cycle.
- `enable` falling during BURST has no effect on the burst in progress.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. In the first cycle after reset is released, arready equals enable.
- Latency: an AR handshake at edge N gives `rvalid=1` with beat 0 valid after edge N. Read data is combinational from the registered address.
- Throughput: with rready held high, there is one beat per cycle. After the last beat's handshake at edge M, arready is high after edge M (when enable=1). The minimum AR-to-AR spacing is therefore len+2 cycles.
- Backpressure: while `rvalid && !rready`, rid, rdata, rresp and rlast hold stable.
- Reset asserted mid-burst: at the next edge the FSM goes to IDLE, all outputs return to their reset values, and the remaining beats are dropped.

## Structure
- `easyaxi_pkg` holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/RESP_SLVERR;
  - the state type {IDLE, BURST}.
- `easyaxi_rd_addr_gen` is a combinational sub-module. Inputs: current addr, start addr, len, size, burst. Output: next addr. It is shared with the master's address path.

## Test plan
- INCR: preload mem[i] = 0xA000_0000 + i. Issue araddr=0x10, arlen=3, arsize=2, rready=1. Expect 4 beats 0xA0000004..0xA0000007, OKAY, rlast only on beat 3, rid echoed.
- WRAP: araddr=0x38, arlen=3, arsize=2. Expect word order 14, 15, 12, 13.
- Backpressure: INCR len=7 with rready toggling 1,0,0,1. Expect R outputs stable while stalled, exactly 8 beats, no duplicates.
- Errors:
  - arsize=3 with DATA_W=32 gives all beats SLVERR with rdata=0.
  - INCR from word 254, len=3, gives OKAY, OKAY, SLVERR, SLVERR.
- Control: enable=0 with arvalid=1 keeps arready=0 indefinitely. A reset pulse at beat 2 of a len=7 burst forces rvalid=0 at the next edge and arready=enable one cycle after release.

Source files
------------

// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI encodings and types.
// Used by the read responder and the master's address path.
package easyaxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/easyaxi_slv_rd_if.sv
// AXI4 read address/data channel bundle.
// Master drives AR and RREADY; slave drives ARREADY and R.
interface easyaxi_slv_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/easyaxi_rd_addr_gen.sv
// Combinational AXI burst address stepper (FIXED/INCR/WRAP).
// Shared between the read responder and the master's address path.
module easyaxi_rd_addr_gen
    import easyaxi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wsize;
    logic [ADDR_W-1:0] base;

    always_comb begin
        step   = ADDR_W'(1) << size_i;
        wsize  = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
        base   = start_i & ~(wsize - ADDR_W'(1));
        next_o = addr_i;
        case (burst_i)
            BURST_INCR: next_o = addr_i + step;
            // wrap window is a power of two whenever the burst is legal
            BURST_WRAP: next_o = base + ((addr_i + step - base) & (wsize - ADDR_W'(1)));
            default:    next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read-channel responder: one AR at a time, bursts served
// from an internal word memory preloaded through a backdoor port.
module easyaxi_slv_rd
    import easyaxi_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int ID_W      = 4,
    parameter  int MEM_DEPTH = 256,
    localparam int MAW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    easyaxi_slv_rd_if.slave   bus,
    input  logic              mem_we_i,
    input  logic [MAW-1:0]    mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam int IW  = ADDR_W - OFF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] start_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] amask;
    logic [IW-1:0]     widx;
    logic              oob;
    logic              bad;
    logic              ar_hs;
    logic              err;

    always_ff @(posedge clk_i) begin
        if (mem_we_i) mem_q[mem_waddr_i] <= mem_wdata_i;
    end

    easyaxi_rd_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr_i  (addr_q),
        .start_i (start_q),
        .len_i   (len_q),
        .size_i  (size_q),
        .burst_i (burst_q),
        .next_o  (addr_nxt)
    );

    assign widx  = addr_q[ADDR_W-1:OFF];
    assign oob   = widx >= IW'(MEM_DEPTH);
    assign bad   = err_q || oob;
    assign ar_hs = (state_q == IDLE) && enable_i && !rst_i && bus.arvalid;

    // legality is judged once at acceptance and held for the whole burst
    always_comb begin
        amask = (ADDR_W'(1) << bus.arsize) - ADDR_W'(1);
        err   = 1'b0;
        if (bus.arsize > 3'(OFF))   err = 1'b1;
        if (bus.arburst == 2'd3)    err = 1'b1;
        if (bus.arburst == BURST_WRAP) begin
            if (!wrap_len_ok(bus.arlen))        err = 1'b1;
            if ((bus.araddr & amask) != '0)     err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = RESP_OKAY;
        bus.rlast   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.arready = enable_i && !rst_i;
                if (ar_hs) begin
                    state_d = BURST;
                    addr_d  = bus.araddr;
                    beat_d  = '0;
                end
            end
            BURST: begin
                bus.rvalid = 1'b1;
                bus.rid    = id_q;
                bus.rlast  = (beat_q == len_q);
                bus.rresp  = bad ? RESP_SLVERR : RESP_OKAY;
                bus.rdata  = bad ? '0 : mem_q[widx[MAW-1:0]];
                if (bus.rready) begin
                    addr_d = addr_nxt;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            start_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            if (ar_hs) begin
                start_q <= bus.araddr;
                len_q   <= bus.arlen;
                size_q  <= bus.arsize;
                burst_q <= bus.arburst;
                id_q    <= bus.arid;
                err_q   <= err;
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed + randomized bench for easyaxi_slv_rd against a
// burst-level reference model of the memory and AXI address rules.
module tb_easyaxi_slv_rd;
    import easyaxi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] m [256];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    beat_t exp_q[$];

    easyaxi_slv_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    easyaxi_slv_rd dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .bus         (bus),
        .mem_we_i    (mem_we),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of a burst, computed from the AXI rules directly.
    function automatic void model(input logic [31:0] a0, input int len,
                                  input int size, input int burst);
        longint unsigned a, s, w, base, word;
        bit err;
        a    = a0;
        s    = 64'd1 << size;
        w    = longint'(len + 1) * s;
        base = a - (a % w);
        err  = (size > 2) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
               (burst == 2 && (a % s) != 0);
        exp_q.delete();
        for (int b = 0; b <= len; b++) begin
            word = a / 4;
            if (err || word >= 256) exp_q.push_back('{32'h0, 2'd2});
            else                    exp_q.push_back('{m[word], 2'd0});
            if (burst == 1)      a = (a + s) % 64'h1_0000_0000;
            else if (burst == 2) a = base + ((a + s - base) % w);
        end
    endfunction

    task automatic preload(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            mem_we    = 1'b1;
            mem_waddr = 8'(i);
            mem_wdata = rnd ? $urandom : 32'hA000_0000 + 32'(i);
            m[i]      = mem_wdata;
            step();
        end
        mem_we = 1'b0;
    endtask

    // mode 0: rready high, 1: pattern 1,0,0,1, 2: random
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                             input int len, input int size, input int burst,
                             input int mode, input bit drop_en);
        int n = 0;
        int cyc = 0;
        int k = 0;
        bit stalled = 0;
        logic [3:0]  sid;
        logic [31:0] sd;
        logic [1:0]  sr;
        logic        sl;
        model(addr, len, size, burst);
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        #1;
        while (!bus.arready && cyc < 50) begin
            step();
            cyc++;
        end
        chk("ar_accept", bus.arready, 1'b1);
        if (!bus.arready) begin
            bus.arvalid = 1'b0;
            return;
        end
        step();
        bus.arvalid = 1'b0;
        chk("rvalid_latency", bus.rvalid, 1'b1);
        if (drop_en) enable = 1'b0;
        cyc = 0;
        while (n <= len && cyc < 2000) begin
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = (k % 4 == 0) || (k % 4 == 3);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            k++;
            #1;
            if (stalled) begin
                chk("stall_rid", bus.rid, sid);
                chk("stall_rdata", bus.rdata, sd);
                chk("stall_rresp", bus.rresp, sr);
                chk("stall_rlast", bus.rlast, sl);
            end
            if (!bus.rvalid) begin
                chk("rvalid_mid", bus.rvalid, 1'b1);
                break;
            end
            if (bus.rready) begin
                chk("rdata", bus.rdata, exp_q[n].data);
                chk("rresp", bus.rresp, exp_q[n].resp);
                chk("rlast", bus.rlast, n == len);
                chk("rid", bus.rid, id);
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                sid = bus.rid;
                sd  = bus.rdata;
                sr  = bus.rresp;
                sl  = bus.rlast;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.rready = 1'b0;
        chk("beat_count", n, len + 1);
        chk("rvalid_end", bus.rvalid, 1'b0);
        chk("arready_end", bus.arready, enable);
        if (drop_en) enable = 1'b1;
    endtask

    initial begin
        int len;
        int size;
        int burst;
        logic [31:0] addr;
        rst         = 1'b1;
        enable      = 1'b1;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.rready  = 1'b0;
        step();
        step();
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_rresp", bus.rresp, 2'd0);
        chk("rst_rid", bus.rid, 4'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_arready", bus.arready, enable);

        preload(1'b0);

        run_burst(4'h5, 32'h10, 3, 2, 1, 0, 1'b0);
        run_burst(4'h9, 32'h38, 3, 2, 2, 0, 1'b0);
        run_burst(4'h3, 32'h40, 7, 2, 1, 1, 1'b1);
        run_burst(4'h1, 32'h0, 3, 3, 1, 0, 1'b0);
        run_burst(4'h2, 32'h3F8, 3, 2, 1, 0, 1'b0);
        run_burst(4'h6, 32'h0C, 3, 2, 0, 2, 1'b0);
        run_burst(4'h7, 32'h34, 2, 2, 2, 0, 1'b0);

        enable      = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h0;
        bus.arlen   = 8'd0;
        bus.arsize  = 3'd2;
        bus.arburst = BURST_INCR;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("disabled_arready", bus.arready, 1'b0);
            step();
        end
        chk("disabled_rvalid", bus.rvalid, 1'b0);
        bus.arvalid = 1'b0;
        enable      = 1'b1;

        model(32'h0, 7, 2, 1);
        bus.arvalid = 1'b1;
        bus.arid    = 4'hA;
        bus.araddr  = 32'h0;
        bus.arlen   = 8'd7;
        bus.arsize  = 3'd2;
        bus.arburst = BURST_INCR;
        #1;
        chk("rb_arready", bus.arready, 1'b1);
        step();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk("rb_rdata", bus.rdata, exp_q[b].data);
            if (b < 2) step();
        end
        rst = 1'b1;
        step();
        chk("rb_rvalid", bus.rvalid, 1'b0);
        chk("rb_rdata0", bus.rdata, 32'd0);
        chk("rb_rid0", bus.rid, 4'd0);
        chk("rb_arready0", bus.arready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rb_release_arready", bus.arready, enable);
        step();
        chk("rb_dropped", bus.rvalid, 1'b0);
        chk("rb_arready1", bus.arready, enable);
        bus.rready = 1'b0;

        preload(1'b1);
        for (int t = 0; t < 40; t++) begin
            size  = $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            addr  = 32'($urandom_range(0, 1100));
            len   = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 3) != 0) begin
                addr = addr & ~((32'd1 << size) - 32'd1);
                case ($urandom_range(0, 3))
                    0:       len = 1;
                    1:       len = 3;
                    2:       len = 7;
                    default: len = 15;
                endcase
            end
            run_burst(4'($urandom), addr, len, size, burst, 2,
                      1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
